// File: rtl/spi_reg_frontend_pkg.sv
// rtl/spi_reg_frontend_pkg.sv - shared constants, FSM encoding and frame-select helper for the SPI front end
package spi_reg_frontend_pkg;

  localparam int         SPI_RW_BIT     = 7;
  localparam logic [6:0] SPI_BCAST_ADDR = 7'h7F;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_SKIP = 3'd4
  } state_t;

  // Broadcast address is write-only; a read to it is never accepted, even if it equals our own address.
  function automatic logic frame_selected(input logic [6:0] devaddr, input logic [6:0] own,
                                          input logic [6:0] bcast, input logic rw);
    return (devaddr == bcast) ? !rw : (devaddr == own);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - multi-stage pin synchronizer with registered rise/fall pulses
module spi_pin_sync #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Reset to zero so a chip select held low across reset release never looks like a new frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      stage_q[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[SYNC_STAGES-1];
      rise_q <= stage_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~stage_q[SYNC_STAGES-1] & prev_q;
    end
  end

  // prev_q carries the level that produced the current pulse, keeping data aligned with edges.
  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_reg_frontend.sv
// rtl/spi_reg_frontend.sv - SPI mode-0 slave decoding {rw,dev},addr,data frames into register bank strobes
module spi_reg_frontend
  import spi_reg_frontend_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 8,
  parameter int         DATA_WIDTH  = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] BCAST_ADDR  = SPI_BCAST_ADDR
) (
  input  logic                  SPI_CLK,
  input  logic                  RST_N,
  input  logic                  SCLK,
  input  logic                  SCSN,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  input  logic [6:0]            dev_addr,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  write_strobe,
  output logic                  read_strobe,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_active
);

  localparam int P_MOSI = 0;
  localparam int P_SCSN = 1;
  localparam int P_SCLK = 2;

  logic [2:0] sync_level;
  logic [2:0] sync_rise;
  logic [2:0] sync_fall;

  spi_pin_sync #(
    .WIDTH       (3),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk_i   (SPI_CLK),
    .rst_ni  (RST_N),
    .pin_i   ({SCLK, SCSN, MOSI}),
    .level_o (sync_level),
    .rise_o  (sync_rise),
    .fall_o  (sync_fall)
  );

  logic sclk_rise, sclk_fall, scsn_rise, scsn_fall, mosi_lvl;
  logic unused_sync;

  assign sclk_rise   = sync_rise[P_SCLK];
  assign sclk_fall   = sync_fall[P_SCLK];
  assign scsn_rise   = sync_rise[P_SCSN];
  assign scsn_fall   = sync_fall[P_SCSN];
  assign mosi_lvl    = sync_level[P_MOSI];
  assign unused_sync = ^{sync_level[P_SCLK], sync_level[P_SCSN], sync_rise[P_MOSI], sync_fall[P_MOSI]};

  state_t                state_q;
  logic [2:0]            bit_cnt_q;
  logic [7:0]            rx_q;
  logic [7:0]            tx_q;
  logic                  rw_q;
  logic                  incr_q;
  logic                  load_q;
  logic                  miso_q;
  logic                  miso_oe_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0] data_in_q;
  logic                  write_strobe_q;
  logic                  read_strobe_q;
  logic                  frame_active_q;

  logic [7:0] rx_byte_d;
  assign rx_byte_d = {rx_q[6:0], mosi_lvl};

  always_ff @(posedge SPI_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= 3'd0;
      rx_q           <= 8'h00;
      tx_q           <= 8'h00;
      rw_q           <= 1'b0;
      incr_q         <= 1'b0;
      load_q         <= 1'b0;
      miso_q         <= 1'b0;
      miso_oe_q      <= 1'b0;
      address_q      <= '0;
      data_in_q      <= '0;
      write_strobe_q <= 1'b0;
      read_strobe_q  <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      write_strobe_q <= 1'b0;
      read_strobe_q  <= 1'b0;
      load_q         <= read_strobe_q;
      if (incr_q) begin
        address_q <= address_q + ADDR_WIDTH'(1);
        incr_q    <= 1'b0;
      end

      if (scsn_rise) begin
        state_q        <= ST_IDLE;
        bit_cnt_q      <= 3'd0;
        frame_active_q <= 1'b0;
        miso_oe_q      <= 1'b0;
        miso_q         <= 1'b0;
      end else if (scsn_fall) begin
        state_q        <= ST_CMD;
        bit_cnt_q      <= 3'd0;
        rw_q           <= 1'b0;
        frame_active_q <= 1'b0;
        miso_oe_q      <= 1'b0;
        miso_q         <= 1'b0;
      end else if (state_q != ST_IDLE) begin
        if (sclk_fall && miso_oe_q) begin
          miso_q <= tx_q[7];
          tx_q   <= {tx_q[6:0], 1'b0};
        end
        if (sclk_rise) begin
          rx_q      <= rx_byte_d;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            case (state_q)
              ST_CMD: begin
                if (frame_selected(rx_byte_d[6:0], dev_addr, BCAST_ADDR, rx_byte_d[SPI_RW_BIT])) begin
                  state_q        <= ST_ADDR;
                  rw_q           <= rx_byte_d[SPI_RW_BIT];
                  miso_oe_q      <= rx_byte_d[SPI_RW_BIT];
                  frame_active_q <= 1'b1;
                end else begin
                  state_q <= ST_SKIP;
                end
              end
              ST_ADDR: begin
                address_q     <= ADDR_WIDTH'(rx_byte_d);
                read_strobe_q <= rw_q;
                state_q       <= ST_DATA;
              end
              ST_DATA: begin
                incr_q <= 1'b1;
                if (rw_q) begin
                  read_strobe_q <= 1'b1;
                end else begin
                  data_in_q      <= DATA_WIDTH'(rx_byte_d);
                  write_strobe_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end

      // Bank answers the cycle after read_strobe; the byte is latched here, before the next SCLK fall.
      if (load_q) tx_q <= 8'(data_out);
    end
  end

  assign MISO         = miso_q;
  assign MISO_OE      = miso_oe_q;
  assign address      = address_q;
  assign data_in      = data_in_q;
  assign write_strobe = write_strobe_q;
  assign read_strobe  = read_strobe_q;
  assign frame_active = frame_active_q;

endmodule
